// File: rtl/regfile_pkg.sv
// Shared types and sizes for the regfile writeback path.
package regfile_pkg;

    localparam int unsigned REG_AW     = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned NUM_WB_REQ = 2;
    localparam int unsigned DATA_W     = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // One writeback request as presented by a requester.
    typedef struct packed {
        logic              valid;
        reg_addr_t         dr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters used to flag RAW hazards on SR1/SR2.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      alloc_valid_i,
    input  reg_addr_t alloc_dr_i,
    output logic      alloc_ready_c_o,
    input  logic      commit_i,
    input  reg_addr_t commit_dr_i,
    input  reg_addr_t sr1_i,
    input  reg_addr_t sr2_i,
    output logic      sr1_busy_c_o,
    output logic      sr2_busy_c_o,
    output logic      sb_err_o
);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             sb_err_q;
    logic             sb_err_d;
    logic             inc_c;

    // A saturated counter refuses the allocation; issue must retry.
    assign alloc_ready_c_o = (cnt_q[alloc_dr_i] != '1);
    assign inc_c           = alloc_valid_i && alloc_ready_c_o;

    assign sr1_busy_c_o = (cnt_q[sr1_i] != '0);
    assign sr2_busy_c_o = (cnt_q[sr2_i] != '0);
    assign sb_err_o     = sb_err_q;

    always_comb begin
        logic inc_r;
        logic dec_r;
        inc_r    = 1'b0;
        dec_r    = 1'b0;
        sb_err_d = sb_err_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_r    = inc_c && (alloc_dr_i == REG_AW'(r));
            dec_r    = commit_i && (commit_dr_i == REG_AW'(r));
            // Simultaneous alloc and commit on one register cancel out.
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_r && !inc_r && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        if (commit_i && (cnt_q[commit_dr_i] == '0)) begin
            sb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (req 0)
// and load (req 1) writeback, with a registered write stage and hazard scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N     = DATA_W,
    parameter int unsigned CNT_W = 2
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 wr_hold,
    input  logic [NUM_WB_REQ-1:0]                req_valid,
    input  logic [NUM_WB_REQ-1:0][REG_AW-1:0]    req_dr,
    input  logic [NUM_WB_REQ-1:0][N-1:0]         req_data,
    output logic [NUM_WB_REQ-1:0]                req_ready,
    output logic                                 LD_REG,
    output logic [REG_AW-1:0]                    DR,
    output logic [N-1:0]                         D_In,
    input  logic                                 alloc_valid,
    input  logic [REG_AW-1:0]                    alloc_dr,
    output logic                                 alloc_ready,
    input  logic [REG_AW-1:0]                    SR1,
    input  logic [REG_AW-1:0]                    SR2,
    output logic                                 sr1_busy,
    output logic                                 sr2_busy,
    output logic                                 sb_err
);

    logic [NUM_WB_REQ-1:0] gnt_c;
    logic                  gidx_c;
    logic                  xfer_c;

    logic                  rr_last_q;
    logic                  rr_last_d;
    logic                  ld_q;
    logic                  ld_d;
    logic [REG_AW-1:0]     dr_q;
    logic [REG_AW-1:0]     dr_d;
    logic [N-1:0]          data_q;
    logic [N-1:0]          data_d;

    // Grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        gnt_c  = '0;
        gidx_c = 1'b0;
        if (!wr_hold) begin
            unique case (req_valid)
                2'b01: begin
                    gnt_c  = 2'b01;
                    gidx_c = 1'b0;
                end
                2'b10: begin
                    gnt_c  = 2'b10;
                    gidx_c = 1'b1;
                end
                2'b11: begin
                    gnt_c  = rr_last_q ? 2'b01 : 2'b10;
                    gidx_c = ~rr_last_q;
                end
                default: begin
                    gnt_c  = '0;
                    gidx_c = 1'b0;
                end
            endcase
        end
    end

    assign xfer_c    = |gnt_c;
    assign req_ready = gnt_c;

    always_comb begin
        rr_last_d = rr_last_q;
        ld_d      = xfer_c;
        dr_d      = dr_q;
        data_d    = data_q;
        if (xfer_c) begin
            rr_last_d = gidx_c;
            dr_d      = req_dr[gidx_c];
            data_d    = req_data[gidx_c];
        end
    end

    // Reset favours req 0 first by marking req 1 as last served.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_last_q <= 1'b1;
            ld_q      <= 1'b0;
            dr_q      <= '0;
            data_q    <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            ld_q      <= ld_d;
            dr_q      <= dr_d;
            data_q    <= data_d;
        end
    end

    assign LD_REG = ld_q;
    assign DR     = dr_q;
    assign D_In   = data_q;

    wb_scoreboard #(
        .CNT_W (CNT_W)
    ) u_sb (
        .clk             (Clk),
        .rst_n           (Reset),
        .alloc_valid_i   (alloc_valid),
        .alloc_dr_i      (alloc_dr),
        .alloc_ready_c_o (alloc_ready),
        .commit_i        (ld_q),
        .commit_dr_i     (dr_q),
        .sr1_i           (SR1),
        .sr2_i           (SR2),
        .sr1_busy_c_o    (sr1_busy),
        .sr2_busy_c_o    (sr2_busy),
        .sb_err_o        (sb_err)
    );

endmodule
